// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART transceiver slice.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    RXS_IDLE,
    RXS_START,
    RXS_DATA,
    RXS_STOP,
    RXS_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TXS_IDLE,
    TXS_START,
    TXS_DATA,
    TXS_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// RXD synchroniser, mid-bit sampling FSM and received-byte register.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DT_BITRATE = 868
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rxd,
  output logic [UART_DATA_BITS-1:0] o_rx_dout,
  output logic                      o_rx_valid,
  output logic                      o_frame_err,
  output logic                      o_rx_idle
);

  localparam int CNT_W = $clog2(DT_BITRATE);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DT_BITRATE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DT_BITRATE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  logic [1:0]                r_sync;
  logic                      w_rxs;
  rx_state_t                 r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [BIT_W-1:0]          r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_dout;
  logic                      r_valid;
  logic                      r_ferr;

  assign w_rxs = r_sync[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= {2{UART_IDLE_LEVEL}};
      r_state <= RXS_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rxd};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RXS_IDLE: begin
          if (!w_rxs) begin
            r_state <= RXS_START;
            r_cnt   <= CNT_HALF;
          end
        end
        RXS_START: begin
          if (r_cnt == '0) begin
            if (!w_rxs) begin
              r_state <= RXS_DATA;
              r_cnt   <= CNT_FULL;
              r_bit   <= '0;
            end else begin
              r_state <= RXS_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RXS_DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
            r_cnt   <= CNT_FULL;
            if (r_bit == BIT_LAST) begin
              r_state <= RXS_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RXS_STOP: begin
          if (r_cnt == '0) begin
            if (w_rxs) begin
              r_dout  <= r_shift;
              r_valid <= 1'b1;
              r_state <= RXS_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= RXS_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RXS_WAIT_HIGH: begin
          // a held-low line (break) must not be decoded as a run of frames
          if (w_rxs) begin
            r_state <= RXS_IDLE;
          end
        end
        default: r_state <= RXS_IDLE;
      endcase
    end
  end

  assign o_rx_dout   = r_dout;
  assign o_rx_valid  = r_valid;
  assign o_frame_err = r_ferr;
  assign o_rx_idle   = (r_state == RXS_IDLE);

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: RX sampler instance, TX shifter and the FIFO ready flag.
module uart_core
  import uart_pkg::*;
#(
  parameter int DT_BITRATE = 868
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RXD,
  output logic                      TXD,
  input  logic                      TX_START,
  input  logic [UART_DATA_BITS-1:0] TX_DIN,
  output logic [UART_DATA_BITS-1:0] RX_DOUT,
  output logic                      RX_VALID,
  output logic                      FRAME_ERR,
  output logic                      TX_BUSY,
  output logic                      RDY_FLAG
);

  localparam int CNT_W = $clog2(DT_BITRATE);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DT_BITRATE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  logic                      w_rx_idle;
  tx_state_t                 r_tx_state;
  logic [CNT_W-1:0]          r_tx_cnt;
  logic [BIT_W-1:0]          r_tx_bit;
  logic [UART_DATA_BITS-1:0] r_tx_shift;
  logic                      r_txd;
  logic                      r_busy;
  logic                      r_rdy;

  uart_rx_sampler #(
    .DT_BITRATE(DT_BITRATE)
  ) u_rx (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_rxd      (RXD),
    .o_rx_dout  (RX_DOUT),
    .o_rx_valid (RX_VALID),
    .o_frame_err(FRAME_ERR),
    .o_rx_idle  (w_rx_idle)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_state <= TXS_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= UART_IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_rdy      <= 1'b1;
    end else begin
      r_rdy <= w_rx_idle && (r_tx_state == TXS_IDLE);
      case (r_tx_state)
        TXS_IDLE: begin
          if (TX_START) begin
            r_tx_shift <= TX_DIN;
            r_txd      <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_cnt   <= CNT_FULL;
            r_tx_state <= TXS_START;
          end
        end
        TXS_START: begin
          if (r_tx_cnt == '0) begin
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= '0;
            r_tx_cnt   <= CNT_FULL;
            r_tx_state <= TXS_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TXS_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= CNT_FULL;
            if (r_tx_bit == BIT_LAST) begin
              r_txd      <= UART_IDLE_LEVEL;
              r_tx_state <= TXS_STOP;
            end else begin
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bit   <= r_tx_bit + 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TXS_STOP: begin
          if (r_tx_cnt == '0) begin
            r_busy     <= 1'b0;
            r_tx_state <= TXS_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: r_tx_state <= TXS_IDLE;
      endcase
    end
  end

  assign TXD      = r_txd;
  assign TX_BUSY  = r_busy;
  assign RDY_FLAG = r_rdy;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core at 16 clocks per bit.
module tb_uart_core;

  localparam int DT = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RXD = 1'b1;
  logic       TX_START = 1'b0;
  logic [7:0] TX_DIN = '0;
  logic       TXD;
  logic [7:0] RX_DOUT;
  logic       RX_VALID;
  logic       FRAME_ERR;
  logic       TX_BUSY;
  logic       RDY_FLAG;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int got_rd = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] last_good = 8'h00;

  always #5 CLK = ~CLK;

  uart_core #(.DT_BITRATE(DT)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RXD      (RXD),
    .TXD      (TXD),
    .TX_START (TX_START),
    .TX_DIN   (TX_DIN),
    .RX_DOUT  (RX_DOUT),
    .RX_VALID (RX_VALID),
    .FRAME_ERR(FRAME_ERR),
    .TX_BUSY  (TX_BUSY),
    .RDY_FLAG (RDY_FLAG)
  );

  always @(negedge CLK) begin
    if (RX_VALID === 1'b1) begin
      valid_cnt++;
      got_q.push_back(RX_DOUT);
    end
    if (FRAME_ERR === 1'b1) ferr_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input bit chk_rdy);
    RXD = 1'b0;
    for (int c = 0; c < DT; c++) begin
      tick();
      if (chk_rdy && c == 2) begin
        checks++;
        if (RDY_FLAG !== 1'b1) begin errors++; $display("FAIL rdy_before_fall: RDY_FLAG=%b expected 1", RDY_FLAG); end
      end
      if (chk_rdy && c == 3) begin
        checks++;
        if (RDY_FLAG !== 1'b0) begin errors++; $display("FAIL rdy_fall: RDY_FLAG=%b expected 0", RDY_FLAG); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (DT) tick();
    end
    RXD = stop_bit;
    for (int c = 0; c < DT; c++) begin
      tick();
      if (chk_rdy && c == 10) begin
        checks++;
        if (RDY_FLAG !== 1'b0) begin errors++; $display("FAIL rdy_at_stop: RDY_FLAG=%b expected 0", RDY_FLAG); end
      end
      if (chk_rdy && c == 11) begin
        checks++;
        if (RDY_FLAG !== 1'b1) begin errors++; $display("FAIL rdy_rise: RDY_FLAG=%b expected 1", RDY_FLAG); end
        checks++;
        if (RX_DOUT !== b) begin errors++; $display("FAIL dout_before_rdy: RX_DOUT=%h expected %h", RX_DOUT, b); end
      end
    end
  endtask

  task automatic check_rx_byte(input string name);
    logic [7:0] exp_b;
    int n;
    n = 0;
    while (got_rd >= got_q.size() && n < 400) begin
      tick();
      n++;
    end
    exp_b = exp_q.pop_front();
    checks++;
    if (got_rd >= got_q.size()) begin
      errors++;
      $display("FAIL %s: no RX_VALID within 400 cycles, expected byte %h", name, exp_b);
    end else begin
      if (got_q[got_rd] !== exp_b) begin
        errors++;
        $display("FAIL %s: RX_DOUT=%h expected %h", name, got_q[got_rd], exp_b);
      end
      got_rd++;
    end
  endtask

  task automatic run_tx(input logic [7:0] b, input bit solo);
    logic       tx_exp_q[$];
    logic [9:0] frame;
    logic       exp_bit;
    logic       bad_val;
    bit         bit_ok;
    bit         busy_ok;
    int         c;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) tx_exp_q.push_back(frame[k]);
    TX_DIN = b;
    TX_START = 1'b1;
    tick();
    TX_START = 1'b0;
    TX_DIN = 8'h00;
    busy_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_bit = tx_exp_q.pop_front();
      bit_ok = 1'b1;
      bad_val = exp_bit;
      for (int j = 0; j < DT; j++) begin
        c = k * DT + j;
        if (TXD !== exp_bit) begin bit_ok = 1'b0; bad_val = TXD; end
        if (TX_BUSY !== 1'b1) busy_ok = 1'b0;
        if (solo && c == 0) begin
          checks++;
          if (RDY_FLAG !== 1'b1) begin errors++; $display("FAIL tx_rdy_lat: RDY_FLAG=%b expected 1", RDY_FLAG); end
        end
        if (solo && c == 1) begin
          checks++;
          if (RDY_FLAG !== 1'b0) begin errors++; $display("FAIL tx_rdy_fall: RDY_FLAG=%b expected 0", RDY_FLAG); end
        end
        if (solo && c == 49) begin TX_START = 1'b1; TX_DIN = 8'hFF; end
        if (solo && c == 50) begin TX_START = 1'b0; TX_DIN = 8'h00; end
        if (solo && c == 10 * DT - 1) TX_START = 1'b1;
        tick();
      end
      checks++;
      if (!bit_ok) begin
        errors++;
        $display("FAIL tx_bit%0d byte %h: TXD=%b expected %b", k, b, bad_val, exp_bit);
      end
    end
    TX_START = 1'b0;
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL tx_busy_len: TX_BUSY dropped, expected high for %0d cycles", 10 * DT); end
    checks++;
    if (TX_BUSY !== 1'b0) begin errors++; $display("FAIL tx_busy_end: TX_BUSY=%b expected 0", TX_BUSY); end
    if (solo) begin
      tick();
      checks++;
      if (TX_BUSY !== 1'b0 || TXD !== 1'b1) begin
        errors++;
        $display("FAIL tx_start_at_end: TX_BUSY=%b TXD=%b expected 0 1", TX_BUSY, TXD);
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    RXD = 1'b1;
    TX_START = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    checks++;
    if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd: TXD=%b expected 1", TXD); end
    checks++;
    if (RDY_FLAG !== 1'b1) begin errors++; $display("FAIL reset_rdy: RDY_FLAG=%b expected 1", RDY_FLAG); end
    checks++;
    if (RX_DOUT !== 8'h00) begin errors++; $display("FAIL reset_dout: RX_DOUT=%h expected 00", RX_DOUT); end
    checks++;
    if (RX_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: RX_VALID=%b FRAME_ERR=%b expected 0 0", RX_VALID, FRAME_ERR);
    end
    checks++;
    if (TX_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: TX_BUSY=%b expected 0", TX_BUSY); end
  endtask

  task automatic test_rx_basic;
    int v0;
    int f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    last_good = 8'hA5;
    send_rx(8'hA5, 1'b1, 1'b1);
    check_rx_byte("rx_a5");
    checks++;
    if (valid_cnt - v0 != 1 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL rx_a5_pulses: valid=%0d ferr=%0d expected 1 0", valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_tx;
    run_tx(8'h3C, 1'b1);
  endtask

  task automatic test_glitch;
    int v0;
    int f0;
    int n;
    bit saw_low;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    saw_low = 1'b0;
    RXD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (RDY_FLAG === 1'b0) saw_low = 1'b1;
    end
    RXD = 1'b1;
    n = 0;
    while (RDY_FLAG !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (!saw_low) begin errors++; $display("FAIL glitch_dip: RDY_FLAG never low, expected a dip"); end
    checks++;
    if (RDY_FLAG !== 1'b1) begin errors++; $display("FAIL glitch_recover: RDY_FLAG=%b expected 1 within 12 cycles", RDY_FLAG); end
    repeat (2 * DT) tick();
    checks++;
    if (valid_cnt != v0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL glitch_pulses: valid=%0d ferr=%0d expected 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_err;
    int v0;
    int f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_rx(8'h55, 1'b0, 1'b0);
    repeat (40) tick();
    checks++;
    if (ferr_cnt - f0 != 1 || valid_cnt != v0) begin
      errors++;
      $display("FAIL ferr_pulse: ferr=%0d valid=%0d expected 1 0", ferr_cnt - f0, valid_cnt - v0);
    end
    checks++;
    if (RX_DOUT !== last_good) begin errors++; $display("FAIL ferr_dout: RX_DOUT=%h expected %h", RX_DOUT, last_good); end
    RXD = 1'b1;
    repeat (DT) tick();
    exp_q.push_back(8'h12);
    last_good = 8'h12;
    send_rx(8'h12, 1'b1, 1'b0);
    check_rx_byte("rx_after_break");
    checks++;
    if (ferr_cnt - f0 != 1 || valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL after_break_pulses: ferr=%0d valid=%0d expected 1 1", ferr_cnt - f0, valid_cnt - v0);
    end
  endtask

  task automatic test_full_duplex;
    exp_q.push_back(8'h81);
    last_good = 8'h81;
    fork
      send_rx(8'h81, 1'b1, 1'b0);
      run_tx(8'h7E, 1'b0);
    join
    RXD = 1'b1;
    check_rx_byte("rx_duplex");
  endtask

  task automatic test_reset_mid_tx;
    int v0;
    int f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    repeat (4) tick();
    TX_DIN = 8'h00;
    TX_START = 1'b1;
    tick();
    TX_START = 1'b0;
    RXD = 1'b0;
    repeat (40) tick();
    checks++;
    if (TXD !== 1'b0 || TX_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_tx: TXD=%b TX_BUSY=%b expected 0 1", TXD, TX_BUSY);
    end
    RST = 1'b1;
    RXD = 1'b1;
    tick();
    checks++;
    if (TXD !== 1'b1) begin errors++; $display("FAIL reset_mid_txd: TXD=%b expected 1", TXD); end
    checks++;
    if (RDY_FLAG !== 1'b1 || TX_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_flags: RDY_FLAG=%b TX_BUSY=%b expected 1 0", RDY_FLAG, TX_BUSY);
    end
    tick();
    RST = 1'b0;
    last_good = 8'h00;
    repeat (12 * DT) tick();
    checks++;
    if (valid_cnt != v0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL reset_mid_pulses: valid=%0d ferr=%0d expected 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
    checks++;
    if (RX_DOUT !== last_good || RDY_FLAG !== 1'b1 || TXD !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_idle: RX_DOUT=%h RDY_FLAG=%b TXD=%b expected %h 1 1", RX_DOUT, RDY_FLAG, TXD, last_good);
    end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_tx();
    test_glitch();
    test_frame_err();
    test_full_duplex();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
